// File: rtl/call_panel_if.sv
// Signal bundle between the call panel front end and its surroundings:
// raw buttons and controller status in, latched requests, chime and arrow out.
interface call_panel_if;
    logic       btn_up_0;
    logic       btn_up_1;
    logic       btn_down_1;
    logic       btn_down_2;
    logic       btn_car_0;
    logic       btn_car_1;
    logic       btn_car_2;
    logic [1:0] current_floor;
    logic       door_open;
    logic       moving_up;
    logic       moving_down;
    logic       call_up_0;
    logic       call_up_1;
    logic       call_down_1;
    logic       call_down_2;
    logic       select_floor_0;
    logic       select_floor_1;
    logic       select_floor_2;
    logic       chime;
    logic [1:0] dir_arrow;

    // Panel side: consumes buttons and status, drives requests and displays.
    modport slave (
        input  btn_up_0, btn_up_1, btn_down_1, btn_down_2,
        input  btn_car_0, btn_car_1, btn_car_2,
        input  current_floor, door_open, moving_up, moving_down,
        output call_up_0, call_up_1, call_down_1, call_down_2,
        output select_floor_0, select_floor_1, select_floor_2,
        output chime, dir_arrow
    );

    // Environment side: presses buttons, reports status, watches the panel.
    modport master (
        output btn_up_0, btn_up_1, btn_down_1, btn_down_2,
        output btn_car_0, btn_car_1, btn_car_2,
        output current_floor, door_open, moving_up, moving_down,
        input  call_up_0, call_up_1, call_down_1, call_down_2,
        input  select_floor_0, select_floor_1, select_floor_2,
        input  chime, dir_arrow
    );
endinterface

// File: rtl/call_panel_interface.sv
// Call panel front end: synchronises and debounces hall/car buttons, holds
// each press as a request until the floor is served, and drives the arrival
// chime and direction arrow from controller status.
module call_panel_interface #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CHIME_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    call_panel_if.slave bus
);
    // Button index map: 0 up_0, 1 up_1, 2 down_1, 3 down_2, 4 car_0, 5 car_1, 6 car_2
    localparam int unsigned NB = 7;
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW = $clog2(CHIME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] CHIME_LOAD = HW'(CHIME_CYCLES);

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    logic [NB-1:0] raw, sync1, sync2, deb, deb_d, armed;
    logic [NB-1:0] req, req_set, req_clr;
    logic [CW-1:0] cnt [NB];
    logic [1:0]    sync_valid;
    dir_t          last_dir, last_dir_next;
    logic [1:0]    arrow;
    logic          door_q;
    logic [HW-1:0] chime_cnt;

    assign raw = {bus.btn_car_2, bus.btn_car_1, bus.btn_car_0,
                  bus.btn_down_2, bus.btn_down_1, bus.btn_up_1, bus.btn_up_0};

    // Synchronise, debounce, and arm each button.
    // A button only arms once a genuine released sample has passed through the
    // synchroniser after reset, so a button held through reset is not taken
    // as a press until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            deb_d      <= '0;
            armed      <= '0;
            sync_valid <= '0;
            for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            deb_d      <= deb;
            sync_valid <= {sync_valid[0], 1'b1};
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                if (sync_valid[1] && !sync2[i]) armed[i] <= 1'b1;
            end
        end
    end

    assign req_set = deb & ~deb_d & armed;

    // Work out which requests the door opening at the current floor serves.
    always_comb begin
        req_clr = '0;
        if (bus.door_open) begin
            unique case (bus.current_floor)
                2'd0: begin
                    req_clr[0] = 1'b1;
                    req_clr[4] = 1'b1;
                end
                2'd1: begin
                    req_clr[5] = 1'b1;
                    unique case (last_dir)
                        DIR_UP:   if (req[1]) req_clr[1] = 1'b1; else req_clr[2] = 1'b1;
                        DIR_DOWN: if (req[2]) req_clr[2] = 1'b1; else req_clr[1] = 1'b1;
                        default: begin
                            req_clr[1] = 1'b1;
                            req_clr[2] = 1'b1;
                        end
                    endcase
                end
                2'd2: begin
                    req_clr[3] = 1'b1;
                    req_clr[6] = 1'b1;
                end
                default: req_clr = '0;
            endcase
        end
    end

    // Request latches; a clear in the same cycle beats a new press.
    always_ff @(posedge clk) begin
        if (rst) req <= '0;
        else     req <= (req | req_set) & ~req_clr;
    end

    // Last travel direction state register.
    always_ff @(posedge clk) begin
        if (rst) last_dir <= DIR_IDLE;
        else     last_dir <= last_dir_next;
    end

    // Last travel direction: follows motion, holds while stopped.
    always_comb begin
        last_dir_next = last_dir;
        if (bus.moving_up)        last_dir_next = DIR_UP;
        else if (bus.moving_down) last_dir_next = DIR_DOWN;
    end

    // Direction arrow and arrival chime timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            arrow     <= 2'b00;
            door_q    <= 1'b0;
            chime_cnt <= '0;
        end else begin
            arrow  <= bus.moving_up ? 2'b01 : (bus.moving_down ? 2'b10 : 2'b00);
            door_q <= bus.door_open;
            if (bus.door_open && !door_q) chime_cnt <= CHIME_LOAD;
            else if (chime_cnt != '0)      chime_cnt <= chime_cnt - 1'b1;
        end
    end

    assign bus.call_up_0      = req[0];
    assign bus.call_up_1      = req[1];
    assign bus.call_down_1    = req[2];
    assign bus.call_down_2    = req[3];
    assign bus.select_floor_0 = req[4];
    assign bus.select_floor_1 = req[5];
    assign bus.select_floor_2 = req[6];
    assign bus.chime          = (chime_cnt != '0);
    assign bus.dir_arrow      = arrow;
endmodule

// File: tb/tb_call_panel_interface.sv
// Bench for call_panel_interface: directed scenario tasks plus a randomized
// run checked against a window-based behavioural model of the panel.
module tb_call_panel_interface;
    localparam int DEB = 4;
    localparam int CHM = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] btn;
    logic [1:0] floor;
    logic       door, mu, md;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    call_panel_if bus();
    assign bus.btn_up_0      = btn[0];
    assign bus.btn_up_1      = btn[1];
    assign bus.btn_down_1    = btn[2];
    assign bus.btn_down_2    = btn[3];
    assign bus.btn_car_0     = btn[4];
    assign bus.btn_car_1     = btn[5];
    assign bus.btn_car_2     = btn[6];
    assign bus.current_floor = floor;
    assign bus.door_open     = door;
    assign bus.moving_up     = mu;
    assign bus.moving_down   = md;

    logic [6:0] dreq;
    assign dreq = {bus.select_floor_2, bus.select_floor_1, bus.select_floor_0,
                   bus.call_down_2, bus.call_down_1, bus.call_up_1, bus.call_up_0};

    call_panel_interface #(.DEBOUNCE_CYCLES(DEB), .CHIME_CYCLES(CHM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- behavioural reference model ----------------
    // A button's accepted level flips once the last DEB synchronised samples
    // (raw taken 2..DEB+1 edges ago) all disagree with it and at least DEB
    // edges have passed since the previous flip. A flip to 1 of an armed
    // button lands as a request one edge later.
    typedef enum {LD_IDLE, LD_UP, LD_DOWN} ld_t;
    logic [63:0] sh [7];
    int          since [7];
    int          age;
    int          cyc = 0;
    int          last_rise;
    logic [6:0]  m_deb, m_armed, m_pend, m_req;
    ld_t         m_ld;
    logic [1:0]  m_arrow;
    logic        m_door_prev;

    always @(posedge clk) begin : model
        logic [6:0]  ndeb, narm, clr;
        logic [63:0] s;
        logic        win;
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                sh[i]    <= '0;
                since[i] <= 0;
            end
            m_deb <= '0; m_armed <= '0; m_pend <= '0; m_req <= '0;
            m_ld <= LD_IDLE; m_arrow <= 2'b00; last_rise <= -1000;
            m_door_prev <= 1'b0; age <= 0;
        end else begin
            clr  = '0;
            ndeb = m_deb;
            narm = m_armed;
            for (int i = 0; i < 7; i++) begin
                s = {sh[i][62:0], btn[i]};
                sh[i] <= s;
                win = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) if (s[j] == m_deb[i]) win = 1'b0;
                if (since[i] + 1 >= DEB && win) begin
                    ndeb[i]  = ~m_deb[i];
                    since[i] <= 0;
                end else begin
                    since[i] <= since[i] + 1;
                end
                if (age >= 2 && !s[2]) narm[i] = 1'b1;
            end
            m_deb   <= ndeb;
            m_armed <= narm;
            m_pend  <= ndeb & ~m_deb & narm;
            age     <= age + 1;
            if (door) begin
                case (floor)
                    2'd0: begin clr[0] = 1'b1; clr[4] = 1'b1; end
                    2'd2: begin clr[3] = 1'b1; clr[6] = 1'b1; end
                    2'd1: begin
                        clr[5] = 1'b1;
                        if (m_ld == LD_UP) begin
                            if (m_req[1]) clr[1] = 1'b1; else clr[2] = 1'b1;
                        end else if (m_ld == LD_DOWN) begin
                            if (m_req[2]) clr[2] = 1'b1; else clr[1] = 1'b1;
                        end else begin
                            clr[1] = 1'b1; clr[2] = 1'b1;
                        end
                    end
                    default: clr = '0;
                endcase
            end
            m_req <= (m_req | m_pend) & ~clr;
            if (mu)      m_ld <= LD_UP;
            else if (md) m_ld <= LD_DOWN;
            m_arrow <= mu ? 2'b01 : (md ? 2'b10 : 2'b00);
            if (door && !m_door_prev) last_rise <= cyc;
            m_door_prev <= door;
        end
    end

    // Chime is high for CHM cycles following the edge that saw the rise.
    logic exp_chime;
    assign exp_chime = ((cyc - 1 - last_rise) < CHM);

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [6:0] mask);
        btn = btn | mask;
        tick(DEB + 4);
        btn = btn & ~mask;
        tick(DEB + 4);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btn = '1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tests_run++;
        if (dreq !== 7'h00 || bus.chime !== 1'b0 || bus.dir_arrow !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_state: req=%0h chime=%0b arrow=%0b expected 0/0/0", dreq, bus.chime, bus.dir_arrow);
        end
        tick(15);
        tests_run++;
        if (dreq !== 7'h00) begin
            tests_failed++;
            $display("FAIL held_through_reset: req=%0h expected 00", dreq);
        end
        btn = '0;
        tick(12);
        btn[0] = 1'b1;
        tick(DEB + 2);
        tests_run++;
        if (bus.call_up_0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_latency_early: call_up_0=%0b expected 0", bus.call_up_0);
        end
        tick(1);
        tests_run++;
        if (bus.call_up_0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL press_latency: call_up_0=%0b expected 1", bus.call_up_0);
        end
        btn[0] = 1'b0;
        tick(DEB + 4);
    endtask

    task automatic test_glitch();
        int len;
        btn[6] = 1'b1;
        tick(DEB - 1);
        btn[6] = 1'b0;
        tick(12);
        tests_run++;
        if (bus.select_floor_2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_reject: select_floor_2=%0b expected 0", bus.select_floor_2);
        end
        len = $urandom_range(DEB, DEB + 4);
        for (int t = 0; t < DEB + 3; t++) begin
            btn[6] = (t < len);
            tick(1);
            if (t == DEB + 1) begin
                tests_run++;
                if (bus.select_floor_2 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL car2_early: select_floor_2=%0b expected 0", bus.select_floor_2);
                end
            end
            if (t == DEB + 2) begin
                tests_run++;
                if (bus.select_floor_2 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL car2_latency: select_floor_2=%0b expected 1", bus.select_floor_2);
                end
            end
        end
        btn[6] = 1'b0;
        tick(12);
        tests_run++;
        if (bus.select_floor_2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_keeps: select_floor_2=%0b expected 1", bus.select_floor_2);
        end
    endtask

    task automatic test_directional();
        floor = 2'd0;
        press(7'b0000110);
        tests_run++;
        if (bus.call_up_1 !== 1'b1 || bus.call_down_1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_setup: up1=%0b down1=%0b expected 1/1", bus.call_up_1, bus.call_down_1);
        end
        mu = 1'b1; tick(5); mu = 1'b0; tick(2);
        floor = 2'd1; door = 1'b1; tick(1); door = 1'b0; tick(1);
        tests_run++;
        if (bus.call_up_1 !== 1'b0 || bus.call_down_1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_up_clear: up1=%0b down1=%0b expected 0/1", bus.call_up_1, bus.call_down_1);
        end
        tick(2);
        door = 1'b1; tick(1); door = 1'b0; tick(1);
        tests_run++;
        if (bus.call_down_1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL dir_fallback_clear: down1=%0b expected 0", bus.call_down_1);
        end
        floor = 2'd3;
        tick(10);
    endtask

    task automatic test_idle_collision();
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        press(7'b0000110);
        tests_run++;
        if (bus.call_up_1 !== 1'b1 || bus.call_down_1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_setup: up1=%0b down1=%0b expected 1/1", bus.call_up_1, bus.call_down_1);
        end
        floor = 2'd1; door = 1'b1; tick(1);
        tests_run++;
        if (bus.call_up_1 !== 1'b0 || bus.call_down_1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_clear: up1=%0b down1=%0b expected 0/0", bus.call_up_1, bus.call_down_1);
        end
        btn[5] = 1'b1;
        tick(DEB + 8);
        tests_run++;
        if (bus.select_floor_1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision: select_floor_1=%0b expected 0", bus.select_floor_1);
        end
        door = 1'b0; btn[5] = 1'b0; floor = 2'd3;
        tick(12);
    endtask

    task automatic test_chime();
        door = 1'b0; tick(12);
        door = 1'b1;
        for (int t = 0; t < CHM + 2; t++) begin
            tick(1);
            tests_run++;
            if (bus.chime !== (t < CHM)) begin
                tests_failed++;
                $display("FAIL chime_single t=%0d: chime=%0b expected %0b", t, bus.chime, (t < CHM));
            end
        end
        door = 1'b0; tick(4);
        for (int t = 0; t < 16; t++) begin
            door = !(t == 3 || t == 4);
            tick(1);
            tests_run++;
            if (bus.chime !== (t < CHM + 5)) begin
                tests_failed++;
                $display("FAIL chime_reload t=%0d: chime=%0b expected %0b", t, bus.chime, (t < CHM + 5));
            end
        end
        door = 1'b0; tick(2);
    endtask

    task automatic test_arrow_invalid();
        md = 1'b1; tick(1);
        tests_run++;
        if (bus.dir_arrow !== 2'b10) begin
            tests_failed++;
            $display("FAIL arrow_down: arrow=%0b expected 10", bus.dir_arrow);
        end
        md = 1'b0; mu = 1'b1; tick(1);
        tests_run++;
        if (bus.dir_arrow !== 2'b01) begin
            tests_failed++;
            $display("FAIL arrow_up: arrow=%0b expected 01", bus.dir_arrow);
        end
        mu = 1'b0; tick(1);
        tests_run++;
        if (bus.dir_arrow !== 2'b00) begin
            tests_failed++;
            $display("FAIL arrow_idle: arrow=%0b expected 00", bus.dir_arrow);
        end
        press(7'h7f);
        tests_run++;
        if (dreq !== 7'h7f) begin
            tests_failed++;
            $display("FAIL all_set: req=%0h expected 7f", dreq);
        end
        floor = 2'd3; door = 1'b1; tick(3);
        tests_run++;
        if (dreq !== 7'h7f) begin
            tests_failed++;
            $display("FAIL floor3_no_clear: req=%0h expected 7f", dreq);
        end
        door = 1'b0; tick(2);
    endtask

    task automatic test_random();
        int hold [7];
        int shown;
        shown = 0;
        for (int i = 0; i < 7; i++) hold[i] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 7; i++) begin
                if (hold[i] == 0) begin
                    btn[i]  = ~btn[i];
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 9) == 0) door = ~door;
            if (!door && $urandom_range(0, 7) == 0) floor = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin mu = 1'b1; md = 1'b0; end
                    1: begin mu = 1'b0; md = 1'b1; end
                    default: begin mu = 1'b0; md = 1'b0; end
                endcase
            end
            rst = ($urandom_range(0, 799) == 0);
            tick(1);
            tests_run++;
            if (dreq !== m_req || bus.chime !== exp_chime || bus.dir_arrow !== m_arrow) begin
                tests_failed++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random c=%0d: req=%0h chime=%0b arrow=%0b expected %0h/%0b/%0b",
                             c, dreq, bus.chime, bus.dir_arrow, m_req, exp_chime, m_arrow);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = '0; floor = 2'd3; door = 1'b0; mu = 1'b0; md = 1'b0;
        @(negedge clk);
        test_reset();
        test_glitch();
        test_directional();
        test_idle_collision();
        test_chime();
        test_arrow_invalid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
